// File: rtl/df_region_perf_monitor.sv
// Performance monitor for an HLS ap_ctrl_chain dataflow region: region occupancy,
// per-process run state, saturating activity/stall counters and start-to-done latency.
module df_region_perf_monitor #(
    parameter int NUM_PROC = 4,
    parameter int CNT_W    = 32,
    parameter int OUT_W    = 8,
    localparam int SEL_W   = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                finish,
    input  logic                region_start,
    input  logic                region_ready,
    input  logic                region_done,
    input  logic [NUM_PROC-1:0] proc_start,
    input  logic [NUM_PROC-1:0] proc_ready,
    input  logic [NUM_PROC-1:0] proc_done,
    input  logic [NUM_PROC-1:0] proc_continue,
    input  logic [NUM_PROC-1:0] proc_in_stall,
    input  logic [NUM_PROC-1:0] proc_out_stall,
    input  logic [SEL_W-1:0]    rd_sel,
    input  logic [2:0]          rd_field,
    output logic [CNT_W-1:0]    rd_data,
    output logic                region_idle,
    output logic [OUT_W-1:0]    region_outstanding,
    output logic [NUM_PROC-1:0] sat_flag,
    output logic                err_underflow,
    output logic                frozen
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_BLOCKED = 2'd2
    } proc_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [OUT_W-1:0] OUT_MAX = '1;
    localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);

    // counter slots 0..5: starts, dones, active, in_stall, out_stall, blocked
    proc_state_t         state_q [NUM_PROC];
    proc_state_t         state_d [NUM_PROC];
    logic [CNT_W-1:0]    cnt_q   [NUM_PROC][6];
    logic [CNT_W-1:0]    cnt_d   [NUM_PROC][6];
    logic [CNT_W-1:0]    lat_q   [NUM_PROC];
    logic [CNT_W-1:0]    lat_d   [NUM_PROC];
    logic [CNT_W-1:0]    last_q  [NUM_PROC];
    logic [CNT_W-1:0]    max_q   [NUM_PROC];
    logic [CNT_W-1:0]    rec_val [NUM_PROC];
    logic [5:0]          inc     [NUM_PROC];
    logic [NUM_PROC-1:0] acc;
    logic [NUM_PROC-1:0] dacc;
    logic [NUM_PROC-1:0] rec_en;
    logic [NUM_PROC-1:0] sat_hit;
    logic [CNT_W-1:0]    rd_mux;
    logic                region_accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    assign acc           = proc_start & proc_ready;
    assign dacc          = proc_done & proc_continue;
    assign region_accept = region_start & region_ready;
    assign region_idle   = (region_outstanding == '0) & ~region_start;

    // Recorded latency counts the accept and the done cycle inclusively, so the
    // value stored is one more than lat_cnt at the moment the done is accepted.
    always_comb begin
        rec_en  = '0;
        sat_hit = '0;
        for (int i = 0; i < NUM_PROC; i++) begin
            state_d[i] = state_q[i];
            lat_d[i]   = lat_q[i];
            rec_val[i] = '0;
            inc[i]     = {state_q[i] == ST_BLOCKED,
                          (state_q[i] == ST_RUN) & proc_out_stall[i],
                          (state_q[i] == ST_RUN) & proc_in_stall[i],
                          state_q[i] != ST_IDLE,
                          dacc[i],
                          acc[i]};
            case (state_q[i])
                ST_IDLE: begin
                    if (acc[i]) begin
                        if (dacc[i]) begin
                            rec_en[i]  = 1'b1;
                            rec_val[i] = CNT_ONE;
                        end else begin
                            state_d[i] = ST_RUN;
                            lat_d[i]   = CNT_ONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (dacc[i]) begin
                        rec_en[i]  = 1'b1;
                        rec_val[i] = sat_inc(lat_q[i]);
                        if (acc[i]) begin
                            lat_d[i] = CNT_ONE;
                        end else begin
                            state_d[i] = ST_IDLE;
                            lat_d[i]   = '0;
                        end
                    end else begin
                        lat_d[i] = sat_inc(lat_q[i]);
                        if (proc_done[i]) begin
                            state_d[i] = ST_BLOCKED;
                        end
                    end
                end
                ST_BLOCKED: begin
                    if (proc_continue[i]) begin
                        rec_en[i]  = 1'b1;
                        rec_val[i] = sat_inc(lat_q[i]);
                        if (acc[i]) begin
                            state_d[i] = ST_RUN;
                            lat_d[i]   = CNT_ONE;
                        end else begin
                            state_d[i] = ST_IDLE;
                            lat_d[i]   = '0;
                        end
                    end else begin
                        lat_d[i] = sat_inc(lat_q[i]);
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    lat_d[i]   = '0;
                end
            endcase
            for (int f = 0; f < 6; f++) begin
                cnt_d[i][f] = inc[i][f] ? sat_inc(cnt_q[i][f]) : cnt_q[i][f];
                if (cnt_d[i][f] == CNT_MAX) begin
                    sat_hit[i] = 1'b1;
                end
            end
            if (lat_d[i] == CNT_MAX) begin
                sat_hit[i] = 1'b1;
            end
        end
    end

    // FSMs always track; statistics only move while not frozen, and clear wipes
    // them while leaving busy processes with a fresh latency count.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_PROC; i++) begin
                state_q[i] <= ST_IDLE;
                lat_q[i]   <= '0;
                last_q[i]  <= '0;
                max_q[i]   <= '0;
                for (int f = 0; f < 6; f++) begin
                    cnt_q[i][f] <= '0;
                end
            end
            sat_flag <= '0;
        end else begin
            for (int i = 0; i < NUM_PROC; i++) begin
                state_q[i] <= state_d[i];
            end
            if (clear) begin
                for (int i = 0; i < NUM_PROC; i++) begin
                    lat_q[i]  <= (state_d[i] != ST_IDLE) ? CNT_ONE : '0;
                    last_q[i] <= '0;
                    max_q[i]  <= '0;
                    for (int f = 0; f < 6; f++) begin
                        cnt_q[i][f] <= '0;
                    end
                end
                sat_flag <= '0;
            end else if (!frozen) begin
                for (int i = 0; i < NUM_PROC; i++) begin
                    lat_q[i] <= lat_d[i];
                    for (int f = 0; f < 6; f++) begin
                        cnt_q[i][f] <= cnt_d[i][f];
                    end
                    if (rec_en[i]) begin
                        last_q[i] <= rec_val[i];
                        if (rec_val[i] > max_q[i]) begin
                            max_q[i] <= rec_val[i];
                        end
                    end
                end
                sat_flag <= sat_flag | sat_hit;
            end
        end
    end

    // Simultaneous accept and done cancel out; underflow only on a lone done.
    always_ff @(posedge clock) begin
        if (reset) begin
            region_outstanding <= '0;
            err_underflow      <= 1'b0;
        end else begin
            if (region_accept && !region_done) begin
                if (region_outstanding != OUT_MAX) begin
                    region_outstanding <= region_outstanding + OUT_ONE;
                end
            end else if (region_done && !region_accept) begin
                if (region_outstanding != '0) begin
                    region_outstanding <= region_outstanding - OUT_ONE;
                end
            end
            if (clear) begin
                err_underflow <= 1'b0;
            end else if (region_done && !region_accept && region_outstanding == '0) begin
                err_underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            frozen <= 1'b0;
        end else if (finish) begin
            frozen <= 1'b1;
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int p = 0; p < NUM_PROC; p++) begin
            if (rd_sel == SEL_W'(p)) begin
                case (rd_field)
                    3'd0:    rd_mux = cnt_q[p][0];
                    3'd1:    rd_mux = cnt_q[p][1];
                    3'd2:    rd_mux = cnt_q[p][2];
                    3'd3:    rd_mux = cnt_q[p][3];
                    3'd4:    rd_mux = cnt_q[p][4];
                    3'd5:    rd_mux = cnt_q[p][5];
                    3'd6:    rd_mux = last_q[p];
                    default: rd_mux = max_q[p];
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_df_region_perf_monitor.sv
// Self-checking bench for df_region_perf_monitor: directed scenarios followed by a
// randomized run, all compared each cycle against a behavioural model.
module tb_df_region_perf_monitor;

    localparam int NP   = 5;
    localparam int CW   = 8;
    localparam int OW   = 4;
    localparam int CMAX = 255;
    localparam int OMAX = 15;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          clear, finish;
    logic          region_start, region_ready, region_done;
    logic [NP-1:0] proc_start, proc_ready, proc_done, proc_continue;
    logic [NP-1:0] proc_in_stall, proc_out_stall;
    logic [2:0]    rd_sel, rd_field;
    logic [CW-1:0] rd_data;
    logic          region_idle;
    logic [OW-1:0] region_outstanding;
    logic [NP-1:0] sat_flag;
    logic          err_underflow, frozen;

    int checks = 0;
    int errors = 0;

    // Model: per process a busy flag, an awaiting-continue flag, cycles elapsed
    // since the accept, and plain integer statistics clamped at CMAX.
    bit            m_busy [NP];
    bit            m_blk  [NP];
    int            m_el   [NP];
    int            m_cnt  [NP][6];
    int            m_last [NP];
    int            m_max  [NP];
    logic [NP-1:0] m_sat = '0;
    int            m_out = 0;
    bit            m_err = 1'b0;
    bit            m_frozen = 1'b0;
    int            m_rd = 0;

    df_region_perf_monitor #(.NUM_PROC(NP), .CNT_W(CW), .OUT_W(OW)) dut (
        .clock(clock), .reset(reset), .clear(clear), .finish(finish),
        .region_start(region_start), .region_ready(region_ready), .region_done(region_done),
        .proc_start(proc_start), .proc_ready(proc_ready), .proc_done(proc_done),
        .proc_continue(proc_continue), .proc_in_stall(proc_in_stall),
        .proc_out_stall(proc_out_stall), .rd_sel(rd_sel), .rd_field(rd_field),
        .rd_data(rd_data), .region_idle(region_idle), .region_outstanding(region_outstanding),
        .sat_flag(sat_flag), .err_underflow(err_underflow), .frozen(frozen)
    );

    always #5 clock = ~clock;

    function automatic int field_val(input int p, input int f);
        if (f < 6) return m_cnt[p][f];
        if (f == 6) return m_last[p];
        return m_max[p];
    endfunction

    task automatic model_step();
        bit a, d, was_busy, was_blk, done_ev, underflow, region_acc;
        int inc [6];
        int lat_val, el_new;
        if (reset) begin
            for (int p = 0; p < NP; p++) begin
                m_busy[p] = 1'b0; m_blk[p] = 1'b0; m_el[p] = 0;
                m_last[p] = 0; m_max[p] = 0;
                for (int f = 0; f < 6; f++) m_cnt[p][f] = 0;
            end
            m_sat = '0; m_out = 0; m_err = 1'b0; m_frozen = 1'b0; m_rd = 0;
            return;
        end
        m_rd = (int'(rd_sel) < NP) ? field_val(int'(rd_sel), int'(rd_field)) : 0;
        for (int p = 0; p < NP; p++) begin
            a = proc_start[p] & proc_ready[p];
            d = proc_done[p] & proc_continue[p];
            was_busy = m_busy[p];
            was_blk  = m_blk[p];
            inc[0] = int'(a);
            inc[1] = int'(d);
            inc[2] = int'(was_busy);
            inc[3] = int'(was_busy && !was_blk && proc_in_stall[p]);
            inc[4] = int'(was_busy && !was_blk && proc_out_stall[p]);
            inc[5] = int'(was_blk);
            done_ev = 1'b0;
            lat_val = 0;
            el_new  = m_el[p];
            if (!was_busy) begin
                if (a && d) begin
                    done_ev = 1'b1; lat_val = 1;
                end else if (a) begin
                    m_busy[p] = 1'b1; el_new = 1;
                end
            end else if ((!was_blk && d) || (was_blk && proc_continue[p])) begin
                done_ev = 1'b1;
                lat_val = m_el[p] + 1;
                m_blk[p] = 1'b0;
                if (a) el_new = 1;
                else begin
                    m_busy[p] = 1'b0; el_new = 0;
                end
            end else begin
                el_new = m_el[p] + 1;
                if (proc_done[p]) m_blk[p] = 1'b1;
            end
            if (clear) begin
                for (int f = 0; f < 6; f++) m_cnt[p][f] = 0;
                m_last[p] = 0; m_max[p] = 0;
                m_el[p] = m_busy[p] ? 1 : 0;
                m_sat[p] = 1'b0;
            end else if (!m_frozen) begin
                for (int f = 0; f < 6; f++) begin
                    if (inc[f] != 0 && m_cnt[p][f] < CMAX) m_cnt[p][f]++;
                    if (m_cnt[p][f] == CMAX) m_sat[p] = 1'b1;
                end
                m_el[p] = el_new;
                if (m_el[p] >= CMAX) m_sat[p] = 1'b1;
                if (done_ev) begin
                    if (lat_val > CMAX) lat_val = CMAX;
                    m_last[p] = lat_val;
                    if (lat_val > m_max[p]) m_max[p] = lat_val;
                end
            end
        end
        region_acc = region_start & region_ready;
        underflow  = 1'b0;
        if (region_acc && !region_done) begin
            if (m_out < OMAX) m_out++;
        end else if (region_done && !region_acc) begin
            if (m_out == 0) underflow = 1'b1;
            else m_out--;
        end
        if (clear) m_err = 1'b0;
        else if (underflow) m_err = 1'b1;
        if (clear) m_frozen = 1'b0;
        else if (finish) m_frozen = 1'b1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        check_output("rd_data", 32'(rd_data), 32'(m_rd));
        check_output("region_outstanding", 32'(region_outstanding), 32'(m_out));
        check_output("region_idle", 32'(region_idle), 32'((m_out == 0) && !region_start));
        check_output("sat_flag", 32'(sat_flag), 32'(m_sat));
        check_output("err_underflow", 32'(err_underflow), 32'(m_err));
        check_output("frozen", 32'(frozen), 32'(m_frozen));
    endtask

    task automatic apply_stimulus();
        model_step();
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        clear = 1'b0; finish = 1'b0;
        region_start = 1'b0; region_ready = 1'b0; region_done = 1'b0;
        proc_start = '0; proc_ready = '0; proc_done = '0; proc_continue = '0;
        proc_in_stall = '0; proc_out_stall = '0;
        rd_sel = '0; rd_field = '0;
    endtask

    task automatic read_field(input int p, input int f, input int exp, input string tag);
        rd_sel   = 3'(p);
        rd_field = 3'(f);
        apply_stimulus();
        check_output(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        int exp_seq [7];
        exp_seq = '{1, 2, 3, 3, 2, 1, 0};
        idle_inputs();
        reset = 1'b1;
        apply_stimulus();
        apply_stimulus();
        reset = 1'b0;
        check_output("reset_idle", 32'(region_idle), 32'd1);
        check_output("reset_outstanding", 32'(region_outstanding), 32'd0);
        check_output("reset_rd_data", 32'(rd_data), 32'd0);
        check_output("reset_sat", 32'(sat_flag), 32'd0);
        check_output("reset_frozen", 32'(frozen), 32'd0);
        check_output("reset_err", 32'(err_underflow), 32'd0);
        apply_stimulus();

        // proc0: accept, 8 busy cycles, done&continue -> latency 10, active 9
        proc_start[0] = 1'b1; proc_ready[0] = 1'b1;
        apply_stimulus();
        proc_start[0] = 1'b0; proc_ready[0] = 1'b0;
        repeat (8) apply_stimulus();
        proc_done[0] = 1'b1; proc_continue[0] = 1'b1;
        apply_stimulus();
        proc_done[0] = 1'b0; proc_continue[0] = 1'b0;
        read_field(0, 6, 10, "p0_last_lat");
        read_field(0, 7, 10, "p0_max_lat");
        read_field(0, 2, 9, "p0_active");
        read_field(0, 0, 1, "p0_starts");
        read_field(0, 1, 1, "p0_dones");

        // proc1: done held while continue low for 3 cycles
        proc_start[1] = 1'b1; proc_ready[1] = 1'b1;
        apply_stimulus();
        proc_start[1] = 1'b0; proc_ready[1] = 1'b0;
        repeat (2) apply_stimulus();
        proc_done[1] = 1'b1;
        repeat (3) apply_stimulus();
        proc_continue[1] = 1'b1;
        apply_stimulus();
        proc_done[1] = 1'b0; proc_continue[1] = 1'b0;
        read_field(1, 5, 3, "p1_blocked");
        read_field(1, 6, 7, "p1_last_lat");
        read_field(1, 1, 1, "p1_dones");
        read_field(1, 2, 6, "p1_active");

        // region occupancy, including a same-cycle accept and done
        for (int i = 0; i < 7; i++) begin
            region_start = (i < 4); region_ready = (i < 4); region_done = (i >= 3);
            apply_stimulus();
            check_output("region_seq_out", 32'(region_outstanding), 32'(exp_seq[i]));
            check_output("region_seq_idle", 32'(region_idle), 32'(exp_seq[i] == 0 && i >= 4));
        end
        apply_stimulus();
        region_done = 1'b0;
        check_output("underflow_err", 32'(err_underflow), 32'd1);
        check_output("underflow_out", 32'(region_outstanding), 32'd0);
        clear = 1'b1;
        apply_stimulus();
        clear = 1'b0;
        check_output("clear_err", 32'(err_underflow), 32'd0);
        read_field(0, 6, 0, "clear_p0_last");
        region_start = 1'b1; region_ready = 1'b1;
        repeat (17) apply_stimulus();
        check_output("outstanding_hold", 32'(region_outstanding), 32'(OMAX));
        region_start = 1'b0; region_ready = 1'b0; region_done = 1'b1;
        repeat (15) apply_stimulus();
        region_done = 1'b0;
        check_output("outstanding_drain", 32'(region_outstanding), 32'd0);

        // proc2 saturation, then clear while still running
        proc_start[2] = 1'b1; proc_ready[2] = 1'b1;
        apply_stimulus();
        proc_start[2] = 1'b0; proc_ready[2] = 1'b0;
        repeat (258) apply_stimulus();
        read_field(2, 2, CMAX, "p2_active_sat");
        check_output("p2_sat_flag", 32'(sat_flag[2]), 32'd1);
        clear = 1'b1;
        apply_stimulus();
        clear = 1'b0;
        read_field(2, 2, 0, "p2_active_cleared");
        check_output("p2_sat_cleared", 32'(sat_flag[2]), 32'd0);
        read_field(2, 2, 1, "p2_still_run");
        proc_done[2] = 1'b1; proc_continue[2] = 1'b1;
        apply_stimulus();
        proc_done[2] = 1'b0; proc_continue[2] = 1'b0;
        read_field(2, 6, 4, "p2_lat_after_clear");

        // proc0 freeze in the middle of an input stall
        proc_start[0] = 1'b1; proc_ready[0] = 1'b1;
        apply_stimulus();
        proc_start[0] = 1'b0; proc_ready[0] = 1'b0; proc_in_stall[0] = 1'b1;
        repeat (2) apply_stimulus();
        finish = 1'b1;
        apply_stimulus();
        finish = 1'b0;
        apply_stimulus();
        proc_in_stall[0] = 1'b0;
        check_output("frozen_set", 32'(frozen), 32'd1);
        read_field(0, 3, 3, "p0_in_stall_frozen");
        proc_done[0] = 1'b1; proc_continue[0] = 1'b1;
        apply_stimulus();
        proc_done[0] = 1'b0; proc_continue[0] = 1'b0;
        read_field(0, 3, 3, "p0_in_stall_held");
        clear = 1'b1;
        apply_stimulus();
        clear = 1'b0;
        check_output("frozen_cleared", 32'(frozen), 32'd0);
        apply_stimulus();
        read_field(0, 2, 0, "p0_idle_after_freeze");

        // proc3 back-to-back done&continue with start&ready
        proc_start[3] = 1'b1; proc_ready[3] = 1'b1;
        apply_stimulus();
        proc_start[3] = 1'b0; proc_ready[3] = 1'b0;
        apply_stimulus();
        proc_start[3] = 1'b1; proc_ready[3] = 1'b1; proc_done[3] = 1'b1; proc_continue[3] = 1'b1;
        apply_stimulus();
        proc_start[3] = 1'b0; proc_ready[3] = 1'b0; proc_done[3] = 1'b0; proc_continue[3] = 1'b0;
        repeat (4) apply_stimulus();
        proc_start[3] = 1'b1; proc_ready[3] = 1'b1; proc_done[3] = 1'b1; proc_continue[3] = 1'b1;
        apply_stimulus();
        proc_start[3] = 1'b0; proc_ready[3] = 1'b0; proc_done[3] = 1'b0; proc_continue[3] = 1'b0;
        read_field(3, 0, 3, "p3_starts");
        read_field(3, 1, 2, "p3_dones");
        read_field(3, 7, 6, "p3_max_lat");
        read_field(3, 6, 6, "p3_last_lat");
        proc_done[3] = 1'b1; proc_continue[3] = 1'b1;
        apply_stimulus();
        proc_done[3] = 1'b0; proc_continue[3] = 1'b0;
        read_field(5, 0, 0, "sel_out_of_range_5");
        read_field(7, 2, 0, "sel_out_of_range_7");

        // randomized traffic with occasional clear, finish and reset
        clear = 1'b1;
        apply_stimulus();
        clear = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset          = ($urandom_range(0, 999) == 0);
            clear          = ($urandom_range(0, 149) == 0);
            finish         = ($urandom_range(0, 199) == 0);
            region_start   = 1'($urandom);
            region_ready   = 1'($urandom);
            region_done    = ($urandom_range(0, 2) == 0);
            proc_start     = NP'($urandom) & NP'($urandom);
            proc_ready     = NP'($urandom);
            proc_done      = NP'($urandom) & NP'($urandom);
            proc_continue  = NP'($urandom);
            proc_in_stall  = NP'($urandom);
            proc_out_stall = NP'($urandom);
            rd_sel         = 3'($urandom);
            rd_field       = 3'($urandom);
            apply_stimulus();
        end
        reset = 1'b0;
        idle_inputs();
        apply_stimulus();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/df_region_perf_monitor.md
Name: df_region_perf_monitor

Overview:
- Synthesizable, parametrised dataflow-region performance monitor for HLS ap_ctrl_chain regions.
- Observes one region-level handshake and NUM_PROC process-level handshakes.
- Tracks region outstanding/idle state, per-process run state, saturating stall/activity counters and start-to-done latency.
- Exposes results through a registered select/readout port; lives beside the dataflow top in simulation and on-chip debug builds.

Parameters:
- NUM_PROC, 4: number of monitored dataflow processes (1..16).
- CNT_W, 32: width of every counter and latency register.
- OUT_W, 8: width of the region outstanding-transaction counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous counter clear; also unfreezes.
- finish  in  1  freeze request; all counters hold from the cycle after it is sampled high.
- region_start / region_ready / region_done  in  1 each  region ap_ctrl handshake.
- proc_start / proc_ready / proc_done / proc_continue  in  NUM_PROC each  per-process handshake, bit i = process i.
- proc_in_stall / proc_out_stall  in  NUM_PROC each  per-process input-FIFO-empty / output-FIFO-full stall indicators.
- rd_sel  in  clog2(NUM_PROC) (min 1)  process index for readout.
- rd_field  in  3  field select.
- rd_data  out  CNT_W  registered readout.
- region_idle  out  1  region idle flag.
- region_outstanding  out  OUT_W  accepted-but-not-done region transactions.
- sat_flag  out  NUM_PROC  sticky per-process saturation flag.
- err_underflow  out  1  sticky: region_done seen while outstanding==0.
- frozen  out  1  counters frozen.

Behaviour:
- Reset: all counters, latencies, rd_data, sat_flag, err_underflow, frozen = 0; all process FSMs = IDLE; region_idle = 1.
- Region accept = region_start & region_ready. Region done = region_done.
- region_outstanding update:
  - +1 on accept only; -1 on done only; unchanged when both occur in the same cycle.
  - Done with outstanding==0 → no decrement, err_underflow set.
  - Accept with outstanding==all-ones → hold value.
- region_idle = (region_outstanding==0) & ~region_start. Combinational from the register and the input.
- Per-process FSM, process i: A = start&ready (accept), D = done&continue (done accept).
  - IDLE: A&D → IDLE, record latency 1. A → RUN, lat_cnt = 1.
  - RUN: D&A → RUN, record lat_cnt, lat_cnt = 1. D → IDLE, record lat_cnt. done & ~continue → BLOCKED. Otherwise lat_cnt += 1.
  - BLOCKED: continue&A → RUN, record lat_cnt, lat_cnt = 1. continue → IDLE, record lat_cnt. Otherwise lat_cnt += 1.
  - Record: last_lat = value; max_lat = max(max_lat, value).
- Per-process counters, each +1 per cycle when its condition holds and not frozen:
  - starts: on A.
  - dones: on D.
  - active: state ≠ IDLE.
  - in_stall: state==RUN & proc_in_stall.
  - out_stall: state==RUN & proc_out_stall.
  - blocked: state==BLOCKED.
- Saturation: every counter and lat_cnt saturates at all-ones; any saturation sets sat_flag[i], sticky until reset/clear.
- Freeze:
  - finish sampled high at edge N sets frozen at N.
  - Counter/latency updates are suppressed from edge N+1 onward.
  - FSMs, region_outstanding and region_idle keep tracking while frozen.
- clear:
  - Zeros all counters, latencies, sat_flag, err_underflow and frozen.
  - FSM states and region_outstanding are preserved.
  - A process in RUN/BLOCKED restarts lat_cnt at 1.
  - clear has priority over finish in the same cycle.
- Readout:
  - rd_data <= field(rd_sel, rd_field), one-cycle latency, updated every cycle.
  - Field encoding: 0 starts, 1 dones, 2 active, 3 in_stall, 4 out_stall, 5 blocked, 6 last_lat, 7 max_lat.
  - rd_sel ≥ NUM_PROC returns 0.
  - Readout reflects the counter value before the same-edge update.
- Reset mid-operation: everything returns to reset values immediately at that edge. Handshakes in that cycle are ignored.

Test Plan:
- Reset, then proc0 start&ready at cycle 2, done&continue at cycle 11 → starts=1, dones=1, active=9, last_lat=max_lat=10; read rd_sel=0, rd_field=6 → rd_data=10 one cycle later.
- Proc1 done at cycle 5, continue held low until cycle 8 → blocked=3, FSM BLOCKED→IDLE at cycle 8, last_lat includes the blocked cycles.
- Region: 3 accepts, then done and accept in the same cycle, then 3 dones → outstanding 1,2,3,3,2,1,0; region_idle=1 only at 0 with start low. Extra done → err_underflow=1, outstanding stays 0.
- CNT_W=4, proc2 in RUN for 20 cycles → active=15, sat_flag[2]=1. clear → counters 0, sat_flag 0, FSM still RUN.
- Proc0 in RUN with in_stall high 4 cycles, finish pulsed mid-stall after 2 → in_stall frozen at 2 (3 if the finish edge counted) and stays constant; frozen=1; FSM still reaches IDLE on done.
- Back-to-back: proc3 done&continue and start&ready in the same cycle twice → starts=3, dones=2, FSM remains RUN, max_lat = longest interval.
